// File: rtl/freq_count_sequencer_if.sv
// Wishbone classic bus between the measurement sequencer (master) and the
// counter peripheral (slave).
//
// Handshake: a transfer is offered while cyc_o and stb_o are both high; adr_o,
// dat_o, we_o and sel_o stay constant for as long as it is offered. The slave
// ends it by raising exactly one of ack_i / err_i / rty_i for one cycle
// (err_i wins over rty_i, rty_i over ack_i). A termination seen while stb_o is
// low means nothing, and the master drops stb_o the cycle after a termination.
interface freq_count_sequencer_if;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [3:0]  sel_o;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  modport master (
    output adr_o, dat_o, we_o, cyc_o, stb_o, sel_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, cyc_o, stb_o, sel_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/freq_count_sequencer.sv
// Frequency-counter measurement sequencer: resets the counter, starts it,
// waits a programmable gate time, then reads the count back over Wishbone.
// Bus errors, retries beyond the limit and slave timeouts abort the run and
// raise a sticky error flag.
module freq_count_sequencer #(
  parameter logic [31:0] CTRL_ADDR   = 32'h8,
  parameter logic [31:0] RESULT_ADDR = 32'h9,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          MAX_RETRY   = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        continuous_i,
  input  logic [15:0] gate_cycles_i,
  freq_count_sequencer_if.master wb,
  output logic [31:0] result_o,
  output logic        result_valid_o,
  output logic        busy_o,
  output logic        error_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_RST   = 3'd1,
    WR_START = 3'd2,
    GATE     = 3'd3,
    RD_RES   = 3'd4,
    DONE     = 3'd5
  } state_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_t      state;
  bus_t        bus_q;
  logic [15:0] gate_lat;
  logic [15:0] gate_cnt;
  logic [15:0] tmo_cnt;
  logic [7:0]  retry_cnt;
  // WR_RST has been acked; the next (idle-bus) cycle moves on to WR_START.
  logic        acked;

  // Bus fields for the single transfer that belongs to each bus state.
  function automatic bus_t issue(state_t s);
    bus_t b;
    b.cyc = 1'b1;
    b.stb = 1'b1;
    b.sel = 4'hF;
    b.we  = (s != RD_RES);
    b.adr = (s == RD_RES) ? RESULT_ADDR : CTRL_ADDR;
    case (s)
      WR_RST:   b.dat = 32'h1;
      WR_START: b.dat = 32'h80;
      default:  b.dat = 32'h0;
    endcase
    return b;
  endfunction

  assign wb.cyc_o = bus_q.cyc;
  assign wb.stb_o = bus_q.stb;
  assign wb.we_o  = bus_q.we;
  assign wb.sel_o = bus_q.sel;
  assign wb.adr_o = bus_q.adr;
  assign wb.dat_o = bus_q.dat;

  assign busy_o  = (state != IDLE);
  assign state_o = state;

  // Sequencer FSM with registered bus, result and error outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      bus_q          <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      error_o        <= 1'b0;
      gate_lat       <= '0;
      gate_cnt       <= '0;
      tmo_cnt        <= '0;
      retry_cnt      <= '0;
      acked          <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i || continuous_i) begin
            gate_lat  <= gate_cycles_i;
            if (start_i) error_o <= 1'b0;
            state     <= WR_RST;
            bus_q     <= issue(WR_RST);
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            acked     <= 1'b0;
          end
        end

        WR_RST, WR_START, RD_RES: begin
          if (!bus_q.stb) begin
            // Idle bus cycle after a retry, or after the WR_RST ack.
            tmo_cnt <= '0;
            if (acked) begin
              acked     <= 1'b0;
              state     <= WR_START;
              bus_q     <= issue(WR_START);
              retry_cnt <= '0;
            end else begin
              bus_q <= issue(state);
            end
          end else if (wb.err_i) begin
            bus_q   <= '0;
            error_o <= 1'b1;
            state   <= IDLE;
          end else if (wb.rty_i) begin
            bus_q <= '0;
            if (retry_cnt == RETRY_MAX) begin
              error_o <= 1'b1;
              state   <= IDLE;
            end else begin
              retry_cnt <= retry_cnt + 8'd1;
            end
          end else if (wb.ack_i) begin
            bus_q <= '0;
            case (state)
              WR_RST: acked <= 1'b1;
              WR_START: begin
                state    <= GATE;
                gate_cnt <= gate_lat;
              end
              default: begin
                result_o       <= wb.dat_i;
                result_valid_o <= 1'b1;
                state          <= DONE;
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            bus_q   <= '0;
            error_o <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        GATE: begin
          if (gate_cnt == '0) begin
            state     <= RD_RES;
            bus_q     <= issue(RD_RES);
            retry_cnt <= '0;
            tmo_cnt   <= '0;
          end else begin
            gate_cnt <= gate_cnt - 16'd1;
          end
        end

        DONE: begin
          if (continuous_i) begin
            state     <= WR_RST;
            bus_q     <= issue(WR_RST);
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            acked     <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          bus_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_count_sequencer.sv
// Bench for freq_count_sequencer: scripted Wishbone slave, transfer log and a
// spec-level model of which transfers a measurement produces.
`timescale 1ns/1ps
module tb_freq_count_sequencer;
  localparam logic [31:0] CTRL_ADDR   = 32'h8;
  localparam logic [31:0] RESULT_ADDR = 32'h9;
  localparam int          ACK_TIMEOUT = 16;
  localparam int          MAX_RETRY   = 3;
  localparam logic [1:0]  R_ACK = 2'd0, R_RTY = 2'd1, R_ERR = 2'd2, R_NONE = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic [15:0] gate_cycles_i = '0;
  logic [31:0] result_o;
  logic        result_valid_o, busy_o, error_o;
  logic [2:0]  state_o;

  freq_count_sequencer_if wb();

  freq_count_sequencer #(
    .CTRL_ADDR(CTRL_ADDR), .RESULT_ADDR(RESULT_ADDR),
    .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .continuous_i(continuous_i),
    .gate_cycles_i(gate_cycles_i), .wb(wb), .result_o(result_o),
    .result_valid_o(result_valid_o), .busy_o(busy_o), .error_o(error_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  logic [64:0] exp_q[$];      // {we, adr, dat} of every expected bus attempt
  logic [64:0] obs_q[$];      // same, as seen on the bus
  logic [1:0]  resp_q[$];     // slave reply per attempt (default ack)
  logic [31:0] rd_q[$];       // data returned on read acks
  int          wait_states = 0;
  int          stab_bad = 0, sel_bad = 0, last_len = 0, rv_pulses = 0;
  int          t_start_ack = -1, t_rd = -1;
  logic [31:0] exp_result = '0;
  logic        exp_error = 1'b0;

  // ---------------- scripted slave and bus monitor ----------------
  initial begin : slave
    logic [64:0] snap;
    logic [1:0]  resp;
    int          wcnt, len;
    bit          in_x;
    in_x = 0; wcnt = 0; len = 0; resp = R_ACK; snap = '0;
    wb.ack_i = 0; wb.err_i = 0; wb.rty_i = 0; wb.dat_i = '0;
    forever begin
      @(negedge clk_i);
      cyc_n++;
      wb.ack_i = 0; wb.err_i = 0; wb.rty_i = 0; wb.dat_i = '0;
      if (result_valid_o) rv_pulses++;
      if (wb.stb_o ? (wb.sel_o !== 4'hF) : (wb.sel_o !== 4'h0)) sel_bad++;
      if (wb.cyc_o && wb.stb_o) begin
        if (!in_x) begin
          in_x = 1; wcnt = 0; len = 0;
          snap = {wb.we_o, wb.adr_o, wb.dat_o};
          obs_q.push_back(snap);
          resp = (resp_q.size() > 0) ? resp_q.pop_front() : R_ACK;
          if (!wb.we_o) t_rd = cyc_n;
        end else if ({wb.we_o, wb.adr_o, wb.dat_o} !== snap) begin
          stab_bad++;
        end
        len++;
        if (resp != R_NONE && wcnt == wait_states) begin
          case (resp)
            R_ACK: begin
              wb.ack_i = 1;
              if (!wb.we_o) wb.dat_i = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
              if (wb.we_o && wb.dat_o == 32'h80) t_start_ack = cyc_n;
            end
            R_RTY:   wb.rty_i = 1;
            default: wb.err_i = 1;
          endcase
          in_x = 0;
        end else begin
          wcnt++;
        end
      end else begin
        if (in_x) last_len = len;
        in_x = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [64:0] make_xfer(int t);
    case (t)
      0:       return {1'b1, CTRL_ADDR, 32'h1};
      1:       return {1'b1, CTRL_ADDR, 32'h80};
      default: return {1'b0, RESULT_ADDR, 32'h0};
    endcase
  endfunction

  // One measurement = reset write, start write, result read. Each slave reply
  // is one attempt; err/timeout end the run, retries beyond MAX_RETRY too.
  task automatic model_run(input logic [1:0] scr[$], input logic [31:0] rd_val);
    int rty;
    bit fail, fin;
    logic [1:0] r;
    fail = 0;
    for (int t = 0; t < 3 && !fail; t++) begin
      rty = 0; fin = 0;
      while (!fin) begin
        r = (scr.size() > 0) ? scr.pop_front() : R_ACK;
        exp_q.push_back(make_xfer(t));
        if (r == R_ACK) fin = 1;
        else if (r == R_RTY) begin
          rty++;
          if (rty > MAX_RETRY) begin fail = 1; fin = 1; end
        end else begin fail = 1; fin = 1; end
      end
    end
    if (fail) exp_error = 1'b1;
    else exp_result = rd_val;
  endtask

  // ---------------- driver tasks ----------------
  task automatic setup(input logic [1:0] scr[$], input logic [31:0] rds[$], input int ws);
    resp_q = scr; rd_q = rds; wait_states = ws;
    obs_q.delete(); exp_q.delete();
    stab_bad = 0; sel_bad = 0; rv_pulses = 0; last_len = 0;
    t_start_ack = -1; t_rd = -1;
  endtask

  task automatic do_start(input logic [15:0] g);
    @(negedge clk_i);
    start_i = 1'b1; gate_cycles_i = g; exp_error = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin ok = 1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [1:0] scr[$];
    logic [31:0] rds[$];
    bit ok;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o, wb.adr_o, wb.dat_o} !== '0) begin
      failures++; $display("FAIL reset_bus got=%h exp=0", {wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o, wb.adr_o, wb.dat_o});
    end
    checks++;
    if ({result_o, result_valid_o, busy_o, error_o} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {result_o, result_valid_o, busy_o, error_o});
    end
    scr = {}; rds = {32'd7};
    setup(scr, rds, 0);
    model_run(scr, 32'd7);
    // Start presented for the very first edge after release.
    rst_i = 1'b1; start_i = 1'b1; gate_cycles_i = 16'd5; exp_error = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    checks++;
    if ({wb.cyc_o, wb.stb_o, wb.adr_o, wb.dat_o} !== {1'b1, 1'b1, CTRL_ADDR, 32'h1}) begin
      failures++; $display("FAIL first_start got=%h exp=%h", {wb.cyc_o, wb.stb_o, wb.adr_o, wb.dat_o}, {1'b1, 1'b1, CTRL_ADDR, 32'h1});
    end
    wait_idle(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL first_run_idle got=busy exp=idle"); end
    checks++;
    if (result_o !== exp_result) begin failures++; $display("FAIL first_run_result got=%0d exp=%0d", result_o, exp_result); end
  endtask

  task automatic test_single();
    logic [1:0] scr[$];
    logic [31:0] rds[$];
    bit ok;
    scr = {}; rds = {32'd15};
    setup(scr, rds, 0);
    model_run(scr, 32'd15);
    do_start(16'd120);
    wait_idle(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_idle got=busy exp=idle"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL single_log_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_xfer%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (result_o !== 32'd15) begin failures++; $display("FAIL single_result got=%0d exp=15", result_o); end
    checks++;
    if (rv_pulses != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", rv_pulses); end
    checks++;
    if (error_o !== 1'b0) begin failures++; $display("FAIL single_error got=%b exp=0", error_o); end
    checks++;
    if (t_rd - t_start_ack < 121 || t_rd - t_start_ack > 122) begin
      failures++; $display("FAIL single_gate got=%0d exp=121..122", t_rd - t_start_ack);
    end
    checks++;
    if (stab_bad != 0 || sel_bad != 0) begin failures++; $display("FAIL single_bus got=%0d/%0d exp=0/0", stab_bad, sel_bad); end
  endtask

  task automatic test_wait_states();
    logic [1:0] scr[$];
    logic [31:0] rds[$];
    logic [31:0] val;
    int g, ws;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      val = $urandom;
      g   = (it == 0) ? 0 : $urandom_range(1, 30);
      ws  = (it == 0) ? 3 : $urandom_range(0, 3);
      scr = {}; rds = {val};
      setup(scr, rds, ws);
      model_run(scr, val);
      do_start(16'(g));
      wait_idle(300, ok);
      checks++;
      if (!ok || obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL ws%0d_log_len got=%0d exp=%0d", it, obs_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL ws%0d_xfer%0d got=%h exp=%h", it, i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (result_o !== exp_result) begin failures++; $display("FAIL ws%0d_result got=%h exp=%h", it, result_o, exp_result); end
      checks++;
      if (stab_bad != 0 || sel_bad != 0) begin failures++; $display("FAIL ws%0d_stable got=%0d/%0d exp=0/0", it, stab_bad, sel_bad); end
      checks++;
      if (t_rd - t_start_ack < g + 1 || t_rd - t_start_ack > g + 2) begin
        failures++; $display("FAIL ws%0d_gate got=%0d exp=%0d..%0d", it, t_rd - t_start_ack, g + 1, g + 2);
      end
    end
  endtask

  task automatic test_retry();
    logic [1:0] scr[$];
    logic [31:0] rds[$];
    bit ok;
    // Two retries on the start write, then ack.
    scr = {R_ACK, R_RTY, R_RTY, R_ACK, R_ACK}; rds = {32'd42};
    setup(scr, rds, 0);
    model_run(scr, 32'd42);
    do_start(16'd3);
    wait_idle(200, ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL retry_ok_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL retry_ok_xfer%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if ({error_o, result_o} !== {exp_error, exp_result}) begin
      failures++; $display("FAIL retry_ok_state got=%b/%0d exp=%b/%0d", error_o, result_o, exp_error, exp_result);
    end
    // Four retries exhaust the budget.
    scr = {R_ACK, R_RTY, R_RTY, R_RTY, R_RTY}; rds = {32'd99};
    setup(scr, rds, 0);
    do_start(16'd3);
    model_run(scr, 32'd99);
    wait_idle(200, ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL retry_ex_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    checks++;
    if ({error_o, result_o} !== {exp_error, exp_result}) begin
      failures++; $display("FAIL retry_ex_state got=%b/%0d exp=%b/%0d", error_o, result_o, exp_error, exp_result);
    end
  endtask

  task automatic test_err_timeout();
    logic [1:0] scr[$];
    logic [31:0] rds[$];
    bit ok;
    scr = {R_ACK, R_ACK, R_ERR}; rds = {32'd5};
    setup(scr, rds, 0);
    do_start(16'd2);
    model_run(scr, 32'd5);
    wait_idle(200, ok);
    checks++;
    if (!ok || {error_o, result_o} !== {exp_error, exp_result}) begin
      failures++; $display("FAIL err_state got=%b/%0d exp=%b/%0d", error_o, result_o, exp_error, exp_result);
    end
    // Read never terminated.
    scr = {R_ACK, R_ACK, R_NONE}; rds = {};
    setup(scr, rds, 0);
    do_start(16'd2);
    checks++;
    if (error_o !== 1'b0) begin failures++; $display("FAIL start_clears_error got=%b exp=0", error_o); end
    model_run(scr, 32'd0);
    wait_idle(200, ok);
    checks++;
    if (!ok || last_len != ACK_TIMEOUT) begin failures++; $display("FAIL timeout_len got=%0d exp=%0d", last_len, ACK_TIMEOUT); end
    checks++;
    if ({error_o, result_o} !== {exp_error, exp_result}) begin
      failures++; $display("FAIL timeout_state got=%b/%0d exp=%b/%0d", error_o, result_o, exp_error, exp_result);
    end
  endtask

  task automatic test_continuous();
    logic [1:0] scr[$];
    logic [31:0] rds[$];
    logic [31:0] seen[$];
    int busy_low;
    bit ok;
    scr = {}; rds = {32'd15, 32'd16};
    setup(scr, rds, 0);
    model_run(scr, 32'd15);
    model_run(scr, 32'd16);
    busy_low = 0;
    @(negedge clk_i);
    continuous_i = 1'b1; gate_cycles_i = 16'd10;
    for (int i = 0; i < 400 && seen.size() < 2; i++) begin
      @(negedge clk_i);
      if (!busy_o) busy_low++;
      if (result_valid_o) begin
        seen.push_back(result_o);
        if (seen.size() == 2) continuous_i = 1'b0;
      end
    end
    continuous_i = 1'b0;
    wait_idle(200, ok);
    checks++;
    if (seen.size() != 2) begin
      failures++; $display("FAIL cont_count got=%0d exp=2", seen.size());
    end else begin
      checks++;
      if (seen[0] !== 32'd15 || seen[1] !== 32'd16) begin
        failures++; $display("FAIL cont_results got=%0d,%0d exp=15,16", seen[0], seen[1]);
      end
    end
    checks++;
    if (busy_low != 0) begin failures++; $display("FAIL cont_busy got=%0d exp=0", busy_low); end
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL cont_log_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL cont_xfer%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    // Continuous re-runs do not clear a sticky error.
    checks++;
    if (error_o !== exp_error) begin failures++; $display("FAIL cont_error got=%b exp=%b", error_o, exp_error); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] scr[$];
    logic [31:0] rds[$];
    bit seen_rd;
    // Reset while gating.
    scr = {}; rds = {32'd77};
    setup(scr, rds, 0);
    exp_q.push_back(make_xfer(0));
    exp_q.push_back(make_xfer(1));
    do_start(16'd200);
    for (int i = 0; i < 50 && t_start_ack < 0; i++) @(negedge clk_i);
    repeat (20) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    exp_result = '0; exp_error = 1'b0;
    checks++;
    if ({wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o, wb.adr_o, wb.dat_o, result_o, result_valid_o, busy_o, error_o} !== '0) begin
      failures++; $display("FAIL gate_reset_outputs got=%b/%b/%0d/%b exp=0/0/0/0", wb.cyc_o, wb.stb_o, result_o, busy_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (300) @(negedge clk_i);
    checks++;
    if (obs_q.size() != exp_q.size() || busy_o !== 1'b0) begin
      failures++; $display("FAIL gate_reset_resume got=%0d xfers exp=%0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL gate_reset_xfer%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    // Reset while the read is on the bus.
    scr = {R_ACK, R_ACK, R_NONE}; rds = {};
    setup(scr, rds, 0);
    do_start(16'd5);
    seen_rd = 0;
    for (int i = 0; i < 60 && !seen_rd; i++) begin
      @(negedge clk_i);
      seen_rd = wb.stb_o && !wb.we_o;
    end
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (!seen_rd || wb.cyc_o !== 1'b0 || wb.stb_o !== 1'b0) begin
      failures++; $display("FAIL xfer_reset_drop got=%b/%b exp=0/0 (read_seen=%b)", wb.cyc_o, wb.stb_o, seen_rd);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (60) @(negedge clk_i);
    checks++;
    if (obs_q.size() != 3 || busy_o !== 1'b0) begin
      failures++; $display("FAIL xfer_reset_resume got=%0d xfers exp=3", obs_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_wait_states();
    test_retry();
    test_err_timeout();
    test_continuous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
